// File: rtl/rc2014_pkg.sv
// Shared widths, bus snapshot type and helpers for the RC2014 I/O-write capture block.
package rc2014_pkg;

    localparam int Z80_ADDR_W  = 8;
    localparam int Z80_DATA_W  = 8;
    localparam int HIT_COUNT_W = 16;

    typedef struct packed {
        logic                  iorq_n;
        logic                  wr_n;
        logic [Z80_ADDR_W-1:0] addr;
        logic [Z80_DATA_W-1:0] data;
    } z80_bus_t;

    // Synchroniser reset value: bus idle (strobes high), address/data zero.
    localparam z80_bus_t BUS_IDLE = '{iorq_n: 1'b1, wr_n: 1'b1, addr: '0, data: '0};

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rc2014_hold_timer.sv
// Per-channel hold timer: load sets the count to HOLD_CYCLES, then it counts down to zero.
module rc2014_hold_timer #(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic active
);

    localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload wins over decrement, so a retrigger restarts the full hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = HOLD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active = (cnt_q != '0);

endmodule

// File: rtl/rc2014_io_latch.sv
// Captures Z80 OUT data for NUM_CH consecutive ports from BASE_ADDR and holds each byte
// visible for HOLD_CYCLES clocks on the LEDs and the per-channel status bus.
module rc2014_io_latch
    import rc2014_pkg::*;
#(
    parameter logic [Z80_ADDR_W-1:0] BASE_ADDR   = 8'h00,
    parameter int                    NUM_CH      = 4,
    parameter int                    HOLD_CYCLES = 25_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             iorq_n,
    input  logic                             wr_n,
    input  logic [Z80_ADDR_W-1:0]            addr,
    input  logic [Z80_DATA_W-1:0]            data,
    input  logic [clog2_min1(NUM_CH)-1:0]    sel,
    output logic [Z80_DATA_W-1:0]            led,
    output logic [Z80_DATA_W*NUM_CH-1:0]     ch_data,
    output logic [NUM_CH-1:0]                ch_active,
    output logic                             hit,
    output logic [clog2_min1(NUM_CH)-1:0]    hit_ch,
    output logic [HIT_COUNT_W-1:0]           hit_count
);

    localparam int CH_W = clog2_min1(NUM_CH);

    z80_bus_t                      bus_s1_q, bus_s1_d;
    z80_bus_t                      bus_s2_q, bus_s2_d;
    logic                          strobe_d_q, strobe_d_d;
    logic [Z80_DATA_W*NUM_CH-1:0]  ch_data_q, ch_data_d;
    logic                          hit_q, hit_d;
    logic [CH_W-1:0]               hit_ch_q, hit_ch_d;
    logic [HIT_COUNT_W-1:0]        hit_count_q, hit_count_d;

    logic                          strobe;
    logic                          strobe_edge;
    logic [Z80_ADDR_W:0]           addr_diff;
    logic                          addr_match;
    logic                          capture;
    logic [CH_W-1:0]               cap_ch;
    logic [NUM_CH-1:0]             load;

    assign strobe      = !bus_s2_q.iorq_n && !bus_s2_q.wr_n;
    assign strobe_edge = strobe && !strobe_d_q;

    // Extra borrow bit flags addresses below BASE_ADDR.
    assign addr_diff  = {1'b0, bus_s2_q.addr} - {1'b0, BASE_ADDR};
    assign addr_match = !addr_diff[Z80_ADDR_W] &&
                        (addr_diff[Z80_ADDR_W-1:0] < Z80_ADDR_W'(NUM_CH));
    assign capture    = strobe_edge && addr_match;
    assign cap_ch     = addr_diff[CH_W-1:0];

    always_comb begin
        bus_s1_d    = '{iorq_n: iorq_n, wr_n: wr_n, addr: addr, data: data};
        bus_s2_d    = bus_s1_q;
        strobe_d_d  = strobe;
        ch_data_d   = ch_data_q;
        hit_d       = capture;
        hit_ch_d    = hit_ch_q;
        hit_count_d = hit_count_q;
        if (capture) begin
            ch_data_d[int'(cap_ch)*Z80_DATA_W +: Z80_DATA_W] = bus_s2_q.data;
            hit_ch_d    = cap_ch;
            hit_count_d = hit_count_q + HIT_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_s1_q    <= BUS_IDLE;
            bus_s2_q    <= BUS_IDLE;
            strobe_d_q  <= 1'b0;
            ch_data_q   <= '0;
            hit_q       <= 1'b0;
            hit_ch_q    <= '0;
            hit_count_q <= '0;
        end else begin
            bus_s1_q    <= bus_s1_d;
            bus_s2_q    <= bus_s2_d;
            strobe_d_q  <= strobe_d_d;
            ch_data_q   <= ch_data_d;
            hit_q       <= hit_d;
            hit_ch_q    <= hit_ch_d;
            hit_count_q <= hit_count_d;
        end
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = capture && (cap_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        rc2014_hold_timer #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_timer (
            .clk   (clk),
            .reset (reset),
            .load  (load[g]),
            .active(ch_active[g])
        );
    end

    // A sel value with no matching channel leaves the LEDs dark.
    always_comb begin
        led = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((sel == CH_W'(i)) && ch_active[i]) begin
                led = ch_data_q[i*Z80_DATA_W +: Z80_DATA_W];
            end
        end
    end

    assign ch_data   = ch_data_q;
    assign hit       = hit_q;
    assign hit_ch    = hit_ch_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_rc2014_io_latch.sv
// Self-checking bench for rc2014_io_latch: directed scenarios plus randomized bus traffic
// checked against a cycle-history reference model.
module tb_rc2014_io_latch;

    localparam logic [7:0] BASE = 8'h40;
    localparam int         NCH  = 4;
    localparam int         HOLD = 10;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        iorq_n = 1'b1;
    logic        wr_n   = 1'b1;
    logic [7:0]  addr   = 8'h00;
    logic [7:0]  data   = 8'h00;
    logic [1:0]  sel    = 2'd0;
    logic [7:0]  led;
    logic [31:0] ch_data;
    logic [3:0]  ch_active;
    logic        hit;
    logic [1:0]  hit_ch;
    logic [15:0] hit_count;

    rc2014_io_latch #(
        .BASE_ADDR  (BASE),
        .NUM_CH     (NCH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iorq_n   (iorq_n),
        .wr_n     (wr_n),
        .addr     (addr),
        .data     (data),
        .sel      (sel),
        .led      (led),
        .ch_data  (ch_data),
        .ch_active(ch_active),
        .hit      (hit),
        .hit_ch   (hit_ch),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the bus looked like in recent cycles, plus capture records.
    int          tc = 0;
    logic        hs_low [5];
    logic [7:0]  ha     [5];
    logic [7:0]  hd     [5];
    logic [7:0]  m_data [NCH];
    int          m_cap  [NCH];
    logic [15:0] m_count;
    int          m_last_ch;
    int          m_hit_tc;

    typedef struct {
        logic       i_n;
        logic       w_n;
        logic [7:0] a;
        logic [7:0] d;
    } cyc_t;
    cyc_t stim[$];

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_data[i] = 8'h00;
            m_cap[i]  = -1;
        end
        for (int k = 0; k < 5; k++) begin
            hs_low[k] = 1'b0;
            ha[k]     = 8'h00;
            hd[k]     = 8'h00;
        end
        m_count   = 16'h0000;
        m_last_ch = 0;
        m_hit_tc  = -1;
    endtask

    // A write is seen when the bus was strobed three cycles ago but not four cycles ago.
    task automatic drive_cycle(input logic rst, input logic i_n, input logic w_n,
                               input logic [7:0] a, input logic [7:0] d);
        int ch;
        @(posedge clk);
        #1;
        reset  = rst;
        iorq_n = i_n;
        wr_n   = w_n;
        addr   = a;
        data   = d;
        tc++;
        if (rst) begin
            model_clear();
        end else begin
            for (int k = 4; k > 0; k--) begin
                hs_low[k] = hs_low[k-1];
                ha[k]     = ha[k-1];
                hd[k]     = hd[k-1];
            end
            hs_low[0] = !i_n && !w_n;
            ha[0]     = a;
            hd[0]     = d;
            if (hs_low[3] && !hs_low[4] &&
                int'(ha[3]) >= int'(BASE) && int'(ha[3]) < int'(BASE) + NCH) begin
                ch            = int'(ha[3]) - int'(BASE);
                m_data[ch]    = hd[3];
                m_cap[ch]     = tc;
                m_count       = m_count + 16'd1;
                m_last_ch     = ch;
                m_hit_tc      = tc;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic exp_active(input int ch);
        return (m_cap[ch] >= 0) && ((tc - m_cap[ch]) < HOLD);
    endfunction

    function automatic logic [3:0] exp_active_vec();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = exp_active(i);
        return v;
    endfunction

    function automatic logic [7:0] exp_led(input logic [1:0] s);
        return exp_active(int'(s)) ? m_data[s] : 8'h00;
    endfunction

    function automatic logic [31:0] exp_ch_data();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    task automatic push_op(input logic i_n, input logic w_n, input logic [7:0] a,
                           input logic [7:0] d, input int low, input int gap);
        cyc_t c;
        for (int k = 0; k < low; k++) begin
            c.i_n = i_n; c.w_n = w_n; c.a = a; c.d = d;
            stim.push_back(c);
        end
        for (int k = 0; k < gap; k++) begin
            c.i_n = 1'b1; c.w_n = 1'b1; c.a = 8'($urandom); c.d = 8'($urandom);
            stim.push_back(c);
        end
    endtask

    task automatic test_reset();
        model_clear();
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        n_tests++;
        if ({led, ch_active, hit_count} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_hold: led=%h act=%h cnt=%h required all zero", led, ch_active, hit_count);
        end
        for (int k = 0; k < 20; k++) begin
            sel = 2'(k);
            drive_cycle(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
            n_tests++;
            if (led !== 8'h00 || ch_active !== 4'h0 || hit !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_outputs: led=%h act=%h hit=%b required 00/0/0", led, ch_active, hit);
            end
            n_tests++;
            if (hit_count !== 16'h0000) begin
                n_fail++;
                $display("FAIL idle_count: got %h required 0000", hit_count);
            end
        end
    endtask

    task automatic test_single_write();
        int hit_at = -1;
        int hits = 0;
        int led_on = 0;
        sel = 2'd2;
        stim.delete();
        push_op(1'b0, 1'b0, 8'h42, 8'hA5, 4, 16);
        foreach (stim[k]) begin
            drive_cycle(1'b0, stim[k].i_n, stim[k].w_n, stim[k].a, stim[k].d);
            if (hit === 1'b1) begin hits++; hit_at = k; end
            if (led === 8'hA5) led_on++;
            n_tests++;
            if (hit !== (m_hit_tc == tc) || led !== exp_led(sel) || ch_active !== exp_active_vec()) begin
                n_fail++;
                $display("FAIL single_cycle%0d: hit=%b led=%h act=%h required %b/%h/%h",
                         k, hit, led, ch_active, (m_hit_tc == tc), exp_led(sel), exp_active_vec());
            end
        end
        n_tests++;
        if (hits !== 1 || hit_at !== 3) begin
            n_fail++;
            $display("FAIL single_latency: hits=%0d at=%0d required 1 at 3", hits, hit_at);
        end
        n_tests++;
        if (led_on !== HOLD) begin
            n_fail++;
            $display("FAIL single_led_cycles: got %0d required %0d", led_on, HOLD);
        end
        n_tests++;
        if (ch_data[23:16] !== 8'hA5 || hit_ch !== 2'd2 || hit_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_state: ch2=%h hit_ch=%0d cnt=%h required A5/2/0001",
                     ch_data[23:16], hit_ch, hit_count);
        end
    endtask

    task automatic test_no_match();
        logic [15:0] cnt_before = m_count;
        logic [31:0] data_before = exp_ch_data();
        stim.delete();
        push_op(1'b0, 1'b0, 8'h44, 8'h55, 4, 4);
        push_op(1'b0, 1'b0, 8'h3F, 8'h55, 4, 4);
        push_op(1'b0, 1'b1, 8'h41, 8'h77, 4, 4);
        push_op(1'b0, 1'b1, 8'h40, 8'h66, 3, 4);
        foreach (stim[k]) begin
            sel = 2'($urandom);
            drive_cycle(1'b0, stim[k].i_n, stim[k].w_n, stim[k].a, stim[k].d);
            n_tests++;
            if (hit !== 1'b0 || hit_count !== cnt_before || ch_data !== data_before) begin
                n_fail++;
                $display("FAIL no_match_cycle%0d: hit=%b cnt=%h data=%h required 0/%h/%h",
                         k, hit, hit_count, ch_data, cnt_before, data_before);
            end
        end
    endtask

    task automatic test_retrigger();
        int act1 = 0;
        sel = 2'd1;
        stim.delete();
        push_op(1'b0, 1'b0, 8'h41, 8'h11, 3, 2);
        push_op(1'b0, 1'b0, 8'h41, 8'h22, 3, 16);
        foreach (stim[k]) begin
            drive_cycle(1'b0, stim[k].i_n, stim[k].w_n, stim[k].a, stim[k].d);
            if (ch_active[1] === 1'b1) act1++;
            n_tests++;
            if (hit !== (m_hit_tc == tc) || led !== exp_led(sel) || ch_active !== exp_active_vec()) begin
                n_fail++;
                $display("FAIL retrig_cycle%0d: hit=%b led=%h act=%h required %b/%h/%h",
                         k, hit, led, ch_active, (m_hit_tc == tc), exp_led(sel), exp_active_vec());
            end
        end
        n_tests++;
        if (act1 !== 5 + HOLD || ch_data[15:8] !== 8'h22) begin
            n_fail++;
            $display("FAIL retrig_hold: active=%0d ch1=%h required %0d/22", act1, ch_data[15:8], 5 + HOLD);
        end
    endtask

    task automatic test_long_strobe();
        int hits = 0;
        sel = 2'd3;
        stim.delete();
        push_op(1'b0, 1'b0, 8'h43, 8'h3C, 50, 5);
        foreach (stim[k]) begin
            drive_cycle(1'b0, stim[k].i_n, stim[k].w_n, stim[k].a, stim[k].d);
            if (hit === 1'b1) hits++;
            n_tests++;
            if (hit !== (m_hit_tc == tc) || hit_count !== m_count) begin
                n_fail++;
                $display("FAIL long_cycle%0d: hit=%b cnt=%h required %b/%h",
                         k, hit, hit_count, (m_hit_tc == tc), m_count);
            end
        end
        n_tests++;
        if (hits !== 1) begin
            n_fail++;
            $display("FAIL long_single_hit: got %0d required 1", hits);
        end
    endtask

    task automatic test_back_to_back();
        int kind;
        stim.delete();
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 19);
            push_op(1'b0, (kind >= 14), 8'($urandom_range(8'h3C, 8'h47)), 8'($urandom),
                    $urandom_range(2, 6), $urandom_range(2, 8));
        end
        foreach (stim[k]) begin
            if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
            drive_cycle(1'b0, stim[k].i_n, stim[k].w_n, stim[k].a, stim[k].d);
            n_tests++;
            if (hit !== (m_hit_tc == tc) || led !== exp_led(sel) || ch_active !== exp_active_vec()) begin
                n_fail++;
                $display("FAIL random_live%0d: hit=%b led=%h act=%h required %b/%h/%h",
                         k, hit, led, ch_active, (m_hit_tc == tc), exp_led(sel), exp_active_vec());
            end
            n_tests++;
            if (ch_data !== exp_ch_data() || hit_count !== m_count || hit_ch !== 2'(m_last_ch)) begin
                n_fail++;
                $display("FAIL random_state%0d: data=%h cnt=%h ch=%0d required %h/%h/%0d",
                         k, ch_data, hit_count, hit_ch, exp_ch_data(), m_count, m_last_ch);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hits = 0;
        sel = 2'd1;
        stim.delete();
        push_op(1'b0, 1'b0, 8'h42, 8'h5A, 6, 0);
        foreach (stim[k]) begin
            drive_cycle(1'b0, stim[k].i_n, stim[k].w_n, stim[k].a, stim[k].d);
            n_tests++;
            if (hit !== (m_hit_tc == tc) || ch_active !== exp_active_vec()) begin
                n_fail++;
                $display("FAIL pre_reset%0d: hit=%b act=%h required %b/%h",
                         k, hit, ch_active, (m_hit_tc == tc), exp_active_vec());
            end
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({led, ch_data, ch_active, hit, hit_ch, hit_count} !== 63'h0) begin
            n_fail++;
            $display("FAIL async_reset: led=%h data=%h act=%h hit=%b ch=%0d cnt=%h required all zero",
                     led, ch_data, ch_active, hit, hit_ch, hit_count);
        end
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b0, 1'b0, 8'h41, 8'hC3);
        stim.delete();
        push_op(1'b0, 1'b0, 8'h41, 8'hC3, 6, 14);
        foreach (stim[k]) begin
            drive_cycle(1'b0, stim[k].i_n, stim[k].w_n, stim[k].a, stim[k].d);
            if (hit === 1'b1) hits++;
            n_tests++;
            if (hit !== (m_hit_tc == tc) || led !== exp_led(sel) || ch_data !== exp_ch_data()) begin
                n_fail++;
                $display("FAIL post_reset%0d: hit=%b led=%h data=%h required %b/%h/%h",
                         k, hit, led, ch_data, (m_hit_tc == tc), exp_led(sel), exp_ch_data());
            end
        end
        n_tests++;
        if (hits !== 1 || ch_data !== 32'h0000_C300 || hit_count !== 16'd1 || hit_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL post_reset_capture: hits=%0d data=%h cnt=%h ch=%0d required 1/0000C300/0001/1",
                     hits, ch_data, hit_count, hit_ch);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_no_match();
        test_retrigger();
        test_long_strobe();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
